// File: rtl/duel_sched_if.sv
// Handshake bundle between the duel round sequencer and its surroundings:
// button/judge pulses in, question index, grant, timer, HP and winner out.
interface duel_sched_if;
  logic       start;
  logic       buzz1;
  logic       buzz2;
  logic       judg_valid;
  logic       judg_ok;
  logic [3:0] num;
  logic       q_load;
  logic [1:0] grant;
  logic [2:0] state;
  logic [3:0] time_left;
  logic [1:0] hp1;
  logic [1:0] hp2;
  logic [1:0] winner;

  modport master (
    output start, buzz1, buzz2, judg_valid, judg_ok,
    input  num, q_load, grant, state, time_left, hp1, hp2, winner
  );

  modport slave (
    input  start, buzz1, buzz2, judg_valid, judg_ok,
    output num, q_load, grant, state, time_left, hp1, hp2, winner
  );
endinterface

// File: rtl/duel_sched.sv
// Two-player duel round sequencer: buzz arbitration with a tie pointer,
// per-second answer timer, HP bookkeeping and winner detection.
module duel_sched #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ANS_SEC       = 9,
  parameter int HP_INIT       = 3,
  parameter int NUM_Q         = 16
) (
  input  logic        clk,
  input  logic        rst,
  duel_sched_if.slave bus
);
  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    OPEN   = 3'd2,
    ANSWER = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t            state_reg;
  logic [3:0]        num_reg;
  logic [3:0]        time_left_reg;
  logic              q_load_reg;
  logic              tie_p2_reg;
  logic              verdict_reg;
  logic [1:0]        grant_reg;
  logic [1:0]        winner_reg;
  logic [1:0]        hp_reg  [2];
  logic [1:0]        hp_next [2];
  logic [TICK_W-1:0] tick_reg;
  logic              tick_wrap;

  assign tick_wrap = (tick_reg == TICK_W'(TICKS_PER_SEC - 1));

  // A player loses a point when it answered wrong or its opponent answered right.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hp
      logic loses;
      assign loses       = grant_reg[gi] ? !verdict_reg : (grant_reg[1-gi] && verdict_reg);
      assign hp_next[gi] = (loses && hp_reg[gi] != 2'd0) ? hp_reg[gi] - 2'd1 : hp_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      num_reg       <= 4'd0;
      time_left_reg <= 4'd0;
      q_load_reg    <= 1'b0;
      tie_p2_reg    <= 1'b0;
      verdict_reg   <= 1'b0;
      grant_reg     <= 2'b00;
      winner_reg    <= 2'b00;
      hp_reg[0]     <= 2'd0;
      hp_reg[1]     <= 2'd0;
      tick_reg      <= '0;
    end else begin
      q_load_reg <= 1'b0;
      case (state_reg)
        IDLE, OVER: begin
          if (bus.start) begin
            state_reg  <= LOAD;
            q_load_reg <= 1'b1;
            hp_reg[0]  <= 2'(HP_INIT);
            hp_reg[1]  <= 2'(HP_INIT);
            num_reg    <= 4'd0;
            winner_reg <= 2'b00;
            grant_reg  <= 2'b00;
          end
        end
        LOAD: begin
          state_reg <= OPEN;
          grant_reg <= 2'b00;
        end
        OPEN: begin
          if (bus.buzz1 || bus.buzz2) begin
            state_reg     <= ANSWER;
            time_left_reg <= 4'(ANS_SEC);
            tick_reg      <= '0;
            if (bus.buzz1 && bus.buzz2) begin
              grant_reg  <= tie_p2_reg ? 2'b10 : 2'b01;
              tie_p2_reg <= !tie_p2_reg;
            end else begin
              grant_reg <= {bus.buzz2, bus.buzz1};
            end
          end
        end
        ANSWER: begin
          if (tick_wrap) begin
            tick_reg      <= '0;
            time_left_reg <= time_left_reg - 4'd1;
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
          // The judge wins over a timeout landing in the same cycle.
          if (bus.judg_valid) begin
            verdict_reg <= bus.judg_ok;
            state_reg   <= RESULT;
          end else if (tick_wrap && time_left_reg == 4'd1) begin
            verdict_reg <= 1'b0;
            state_reg   <= RESULT;
          end
        end
        RESULT: begin
          hp_reg[0] <= hp_next[0];
          hp_reg[1] <= hp_next[1];
          grant_reg <= 2'b00;
          if (hp_next[0] == 2'd0) begin
            winner_reg <= 2'b10;
            state_reg  <= OVER;
          end else if (hp_next[1] == 2'd0) begin
            winner_reg <= 2'b01;
            state_reg  <= OVER;
          end else begin
            num_reg    <= (num_reg == 4'(NUM_Q - 1)) ? 4'd0 : num_reg + 4'd1;
            q_load_reg <= 1'b1;
            state_reg  <= LOAD;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

  assign bus.state     = state_reg;
  assign bus.num       = num_reg;
  assign bus.q_load    = q_load_reg;
  assign bus.grant     = grant_reg;
  assign bus.time_left = time_left_reg;
  assign bus.hp1       = hp_reg[0];
  assign bus.hp2       = hp_reg[1];
  assign bus.winner    = winner_reg;
endmodule
